// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - shared boundary-mode and direction constants for the timer counter
package timer_counter_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_ONESHOT = 2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_step.sv
// rtl/counter_step.sv - combinational next-count and boundary detection for one counter channel
module counter_step
  import timer_counter_pkg::*;
#(
  parameter int              WIDTH = 32,
  parameter longint unsigned INC   = 1,
  parameter longint unsigned TOP   = (64'd1 << WIDTH) - 1,
  parameter int              MODE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_next,
  output logic             o_boundary
);

  localparam logic [WIDTH-1:0] TOP_W = WIDTH'(TOP);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  localparam logic [WIDTH:0]   TOP_X = (WIDTH+1)'(TOP);

  // Up-count sum carries one extra bit so a step past TOP is never lost to overflow
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_up_bnd;
  logic             w_dn_bnd;

  assign w_sum    = {1'b0, i_count} + {1'b0, INC_W};
  assign w_diff   = i_count - INC_W;
  assign w_up_bnd = (w_sum > TOP_X);
  assign w_dn_bnd = (i_count < INC_W);

  always_comb begin
    o_boundary = 1'b0;
    o_next     = i_count;
    if (i_dir == DIR_DOWN) begin
      o_boundary = w_dn_bnd;
      if (!w_dn_bnd)               o_next = w_diff;
      else if (MODE == MODE_SAT)   o_next = '0;
      else                         o_next = TOP_W;
    end else begin
      o_boundary = w_up_bnd;
      if (!w_up_bnd)               o_next = w_sum[WIDTH-1:0];
      else if (MODE == MODE_SAT)   o_next = TOP_W;
      else                         o_next = '0;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - parametrised up/down timer with wrap/sat/one-shot modes and sticky compare irq
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter longint unsigned INC       = 1,
  parameter longint unsigned TOP       = (64'd1 << WIDTH) - 1,
  parameter longint unsigned RESET_VAL = 0,
  parameter int              MODE      = MODE_WRAP
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] cmp_value,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             irq,
  output logic             wrap,
  output logic             done
);

  localparam logic [WIDTH-1:0] TOP_W   = WIDTH'(TOP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  generate
    if (WIDTH < 2 || WIDTH > 32 || INC == 0 || INC > TOP || RESET_VAL > TOP ||
        (TOP >> WIDTH) != 0 || MODE < 0 || MODE > 2) begin : g_bad_params
      $error("timer_counter: illegal parameter combination");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic             r_irq;
  logic             r_wrap;
  logic             r_done;
  logic [WIDTH-1:0] w_next;
  logic             w_boundary;
  logic [WIDTH-1:0] w_load_clamped;

  counter_step #(
    .WIDTH (WIDTH),
    .INC   (INC),
    .TOP   (TOP),
    .MODE  (MODE)
  ) u_step (
    .i_count    (r_count),
    .i_dir      (dir),
    .o_next     (w_next),
    .o_boundary (w_boundary)
  );

  assign w_load_clamped = (load_value > TOP_W) ? TOP_W : load_value;

  // Priority: reset > load > step > hold; a compare match on a step beats irq_clr
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count <= RESET_W;
      r_irq   <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      if (irq_clr) r_irq <= 1'b0;
    end else if (en && !r_done) begin
      r_count <= w_next;
      r_wrap  <= w_boundary;
      if (MODE == MODE_ONESHOT && w_boundary) r_done <= 1'b1;
      if (w_next == cmp_value) r_irq <= 1'b1;
      else if (irq_clr)        r_irq <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (irq_clr) r_irq <= 1'b0;
    end
  end

  assign count = r_count;
  assign irq   = r_irq;
  assign wrap  = r_wrap;
  assign done  = r_done;

endmodule
